// File: rtl/mem_crc_pkg.sv
// Shared types and the CRC helper for the CRC-protected memory controller.
package mem_crc_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, READ, SCRUB} state_e;

  localparam int CRC_MAX_DW = 64;
  localparam int CRC_MAX_PW = 32;

  // MSB-first LFSR, init 0, no final XOR; dw/pw select the live widths.
  function automatic logic [CRC_MAX_PW-1:0] crc_calc(
    input logic [CRC_MAX_DW-1:0] data,
    input logic [CRC_MAX_PW-1:0] poly,
    input int                    dw,
    input int                    pw
  );
    logic [CRC_MAX_PW-1:0] crc;
    logic                  fb;
    crc = '0;
    for (int i = CRC_MAX_DW - 1; i >= 0; i--) begin
      if (i < dw) begin
        fb  = data[i] ^ crc[pw-1];
        crc = crc << 1;
        if (fb) crc = crc ^ poly;
      end
    end
    for (int b = 0; b < CRC_MAX_PW; b++) begin
      if (b >= pw) crc[b] = 1'b0;
    end
    return crc;
  endfunction

endpackage

// File: rtl/mem_crc_ctrl_if.sv
// Host request/response port of the CRC memory controller.
interface mem_crc_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_crc_gen.sv
// Combinational CRC generator wrapped around the package helper.
module mem_crc_gen
  import mem_crc_pkg::*;
#(
  parameter int          DATA_WIDTH      = 8,
  parameter int          POLYNOMIAL_BITS = 1,
  parameter int unsigned POLY            = 1
) (
  input  logic [DATA_WIDTH-1:0]      data,
  output logic [POLYNOMIAL_BITS-1:0] crc
);

  logic [CRC_MAX_PW-1:0]              crc_full;
  logic [CRC_MAX_PW-POLYNOMIAL_BITS:0] crc_unused;

  assign crc_full = crc_calc(CRC_MAX_DW'(data), CRC_MAX_PW'(POLY), DATA_WIDTH, POLYNOMIAL_BITS);
  assign {crc_unused, crc} = {1'b0, crc_full};

endmodule

// File: rtl/mem_crc_ctrl.sv
// Sequencer for a CRC-protected register-file memory: host read/write plus idle-time scrubber.
//   state | meaning
//   IDLE  | accept host request (priority) or grant a pending scrub
//   WRITE | drive mem_wr with captured data and generated CRC
//   READ  | check stored CRC of host address, register response
//   SCRUB | check stored CRC of scrub_addr, advance scrub_addr
module mem_crc_ctrl
  import mem_crc_pkg::*;
#(
  parameter int          DATA_WIDTH      = 8,
  parameter int          POLYNOMIAL_BITS = 1,
  parameter int unsigned POLY            = 1,
  parameter int          ADDR_WIDTH      = 8,
  parameter int          SCRUB_INTERVAL  = 64,
  parameter int          ERR_CNT_WIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  mem_crc_ctrl_if.slave              host,
  input  logic                       scrub_en,
  input  logic                       err_clr,
  output logic                       err_flag,
  output logic [ADDR_WIDTH-1:0]      err_addr,
  output logic [ERR_CNT_WIDTH-1:0]   err_cnt,
  output logic                       scrub_pass_done,
  output logic                       mem_wr,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_data_in,
  output logic [POLYNOMIAL_BITS-1:0] crc_data_in,
  input  logic [DATA_WIDTH-1:0]      mem_data_out,
  input  logic [POLYNOMIAL_BITS-1:0] crc_data_out
);

  localparam int CNT_W = $clog2(SCRUB_INTERVAL + 1);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(SCRUB_INTERVAL - 1);

  state_e                     state, state_nxt;
  logic [ADDR_WIDTH-1:0]      scrub_addr;
  logic [CNT_W-1:0]           int_cnt;
  logic                       scrub_pending;
  logic                       scrub_grant;
  logic [POLYNOMIAL_BITS-1:0] rd_crc;
  logic                       mismatch;

  mem_crc_gen #(.DATA_WIDTH(DATA_WIDTH), .POLYNOMIAL_BITS(POLYNOMIAL_BITS), .POLY(POLY))
    u_wr_crc (.data(mem_data_in), .crc(crc_data_in));

  mem_crc_gen #(.DATA_WIDTH(DATA_WIDTH), .POLYNOMIAL_BITS(POLYNOMIAL_BITS), .POLY(POLY))
    u_rd_crc (.data(mem_data_out), .crc(rd_crc));

  assign mismatch    = ((state == READ) || (state == SCRUB)) && (rd_crc != crc_data_out);
  assign scrub_grant = (state == IDLE) && !host.req_valid && scrub_en && scrub_pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    host.req_ready = 1'b0;
    mem_wr         = 1'b0;
    case (state)
      IDLE: begin
        host.req_ready = 1'b1;
        if (host.req_valid)  state_nxt = host.req_wr ? WRITE : READ;
        else if (scrub_grant) state_nxt = SCRUB;
      end
      WRITE: begin
        mem_wr    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // mem_addr is only reloaded on a grant so it holds its last value while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr       <= '0;
      mem_data_in    <= '0;
      host.rsp_valid <= 1'b0;
      host.rsp_rdata <= '0;
      host.rsp_err   <= 1'b0;
    end else begin
      host.rsp_valid <= 1'b0;
      if (state == IDLE) begin
        if (host.req_valid) begin
          mem_addr <= host.req_addr;
          if (host.req_wr) mem_data_in <= host.req_wdata;
        end else if (scrub_grant) begin
          mem_addr <= scrub_addr;
        end
      end
      if (state == WRITE) begin
        host.rsp_valid <= 1'b1;
        host.rsp_rdata <= '0;
        host.rsp_err   <= 1'b0;
      end
      if (state == READ) begin
        host.rsp_valid <= 1'b1;
        host.rsp_rdata <= mem_data_out;
        host.rsp_err   <= mismatch;
      end
    end
  end

  // Interval counter freezes while a scrub is pending; the grant cycle counts so the period stays SCRUB_INTERVAL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scrub_addr      <= '0;
      scrub_pass_done <= 1'b0;
      int_cnt         <= '0;
      scrub_pending   <= 1'b0;
    end else begin
      scrub_pass_done <= 1'b0;
      if (state == SCRUB) begin
        scrub_addr      <= scrub_addr + 1'b1;
        scrub_pass_done <= &scrub_addr;
      end
      if (!scrub_en) begin
        int_cnt       <= '0;
        scrub_pending <= 1'b0;
      end else if (!scrub_pending || scrub_grant) begin
        if (int_cnt == CNT_TC) begin
          int_cnt       <= '0;
          scrub_pending <= 1'b1;
        end else begin
          int_cnt       <= int_cnt + 1'b1;
          scrub_pending <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_flag <= 1'b0;
      err_addr <= '0;
      err_cnt  <= '0;
    end else if (mismatch) begin
      err_flag <= 1'b1;
      err_addr <= mem_addr;
      if (err_clr)       err_cnt <= ERR_CNT_WIDTH'(1);
      else if (!(&err_cnt)) err_cnt <= err_cnt + 1'b1;
    end else if (err_clr) begin
      err_flag <= 1'b0;
      err_cnt  <= '0;
    end
  end

endmodule

// File: tb/tb_mem_crc_ctrl.sv
// Directed bench for mem_crc_ctrl: table-driven host ops plus scrub, saturation and reset sequences.
module tb_mem_crc_ctrl;

  logic       clk;
  logic       rst_n;
  logic       scrub_en;
  logic       err_clr;
  logic       err_flag;
  logic [7:0] err_addr;
  logic [7:0] err_cnt;
  logic       scrub_pass_done;
  logic       mem_wr;
  logic [7:0] mem_addr;
  logic [7:0] mem_data_in;
  logic [0:0] crc_data_in;
  logic [7:0] mem_data_out;
  logic [0:0] crc_data_out;

  mem_crc_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) host_if ();

  mem_crc_ctrl #(
    .DATA_WIDTH(8), .POLYNOMIAL_BITS(1), .POLY(1),
    .ADDR_WIDTH(8), .SCRUB_INTERVAL(4), .ERR_CNT_WIDTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .host(host_if),
    .scrub_en(scrub_en), .err_clr(err_clr),
    .err_flag(err_flag), .err_addr(err_addr), .err_cnt(err_cnt),
    .scrub_pass_done(scrub_pass_done),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .crc_data_in(crc_data_in), .mem_data_out(mem_data_out), .crc_data_out(crc_data_out)
  );

  // Memory model with a corruption port for the stored CRC
  logic [7:0] mem_d [256];
  logic       mem_c [256];
  logic       mem_init;
  logic       corrupt_en;
  logic [7:0] corrupt_addr;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 256; k++) begin
        mem_d[k] <= 8'h00;
        mem_c[k] <= 1'b0;
      end
    end else begin
      if (mem_wr) begin
        mem_d[mem_addr] <= mem_data_in;
        mem_c[mem_addr] <= crc_data_in[0];
      end
      if (corrupt_en) mem_c[corrupt_addr] <= 1'b0;
    end
  end

  assign mem_data_out = mem_d[mem_addr];
  assign crc_data_out = mem_c[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       corrupt;
    logic       exp_crc;
    logic [7:0] exp_rdata;
    logic       exp_err;
  } vec_t;

  vec_t vecs [10];

  logic       o_ready, o_mem_wr, o_crc, o_rv, o_err, o_rv2;
  logic [7:0] o_addr, o_din, o_rdata;

  // Starts and ends at a negedge with the DUT idle; clr is held during the access cycle
  task automatic do_op(input logic wr, input logic [7:0] addr, input logic [7:0] wdata, input logic clr);
    host_if.req_valid = 1'b1;
    host_if.req_wr    = wr;
    host_if.req_addr  = addr;
    host_if.req_wdata = wdata;
    o_ready = host_if.req_ready;
    @(posedge clk); @(negedge clk);
    host_if.req_valid = 1'b0;
    err_clr  = clr;
    o_mem_wr = mem_wr;
    o_addr   = mem_addr;
    o_din    = mem_data_in;
    o_crc    = crc_data_in[0];
    @(posedge clk); @(negedge clk);
    err_clr = 1'b0;
    o_rv    = host_if.rsp_valid;
    o_rdata = host_if.rsp_rdata;
    o_err   = host_if.rsp_err;
    @(posedge clk); @(negedge clk);
    o_rv2 = host_if.rsp_valid;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_done, pulses, acc, rsp, scrub_seen, rsp_after;

    vecs[0] = '{1'b1, 8'h10, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0};
    vecs[2] = '{1'b1, 8'h03, 8'h07, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[3] = '{1'b0, 8'h03, 8'h00, 1'b0, 1'b0, 8'h07, 1'b1};
    vecs[4] = '{1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0};
    vecs[6] = '{1'b1, 8'h00, 8'h01, 1'b0, 1'b1, 8'h00, 1'b0};
    vecs[7] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0};
    vecs[8] = '{1'b1, 8'h42, 8'h0B, 1'b0, 1'b1, 8'h00, 1'b0};
    vecs[9] = '{1'b0, 8'h42, 8'h00, 1'b0, 1'b0, 8'h0B, 1'b0};

    rst_n = 1'b0; mem_init = 1'b1; corrupt_en = 1'b0; corrupt_addr = 8'h00;
    scrub_en = 1'b0; err_clr = 1'b0;
    host_if.req_valid = 1'b0; host_if.req_wr = 1'b0;
    host_if.req_addr = 8'h00; host_if.req_wdata = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; mem_init = 1'b0;

    chk("reset req_ready", host_if.req_ready, 1);
    chk("reset rsp_valid", host_if.rsp_valid, 0);
    chk("reset mem_wr", mem_wr, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset err_flag", err_flag, 0);
    chk("reset err_cnt", err_cnt, 0);
    chk("reset pass_done", scrub_pass_done, 0);

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0);
      chk($sformatf("v%0d ready", i), o_ready, 1);
      chk($sformatf("v%0d mem_wr", i), o_mem_wr, vecs[i].wr);
      chk($sformatf("v%0d mem_addr", i), o_addr, vecs[i].addr);
      if (vecs[i].wr) begin
        chk($sformatf("v%0d mem_data_in", i), o_din, vecs[i].wdata);
        chk($sformatf("v%0d crc_data_in", i), o_crc, vecs[i].exp_crc);
      end
      chk($sformatf("v%0d rsp_valid", i), o_rv, 1);
      chk($sformatf("v%0d rsp_rdata", i), o_rdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d rsp_err", i), o_err, vecs[i].exp_err);
      chk($sformatf("v%0d rsp pulse end", i), o_rv2, 0);
      if (vecs[i].corrupt) begin
        corrupt_addr = vecs[i].addr; corrupt_en = 1'b1;
        @(posedge clk); @(negedge clk);
        corrupt_en = 1'b0;
      end
    end
    chk("table err_flag", err_flag, 1);
    chk("table err_addr", err_addr, 8'h03);
    chk("table err_cnt", err_cnt, 1);

    // Drive err_cnt to saturation, then one more, then clear colliding with a mismatch
    for (int i = 0; i < 254; i++) do_op(1'b0, 8'h03, 8'h00, 1'b0);
    chk("sat err_cnt 255", err_cnt, 8'hFF);
    do_op(1'b0, 8'h03, 8'h00, 1'b0);
    chk("sat err_cnt held", err_cnt, 8'hFF);
    chk("sat rsp_err", o_err, 1);
    do_op(1'b0, 8'h03, 8'h00, 1'b1);
    chk("clr+mismatch err_cnt", err_cnt, 1);
    chk("clr+mismatch err_flag", err_flag, 1);
    err_clr = 1'b1;
    @(posedge clk); @(negedge clk);
    err_clr = 1'b0;
    chk("clr err_flag", err_flag, 0);
    chk("clr err_cnt", err_cnt, 0);

    // Full scrub pass at interval 4: grant k at edge 5+4k, done pulse after edge 1026
    scrub_en = 1'b1;
    first_done = -1; pulses = 0;
    for (int n = 1; n <= 1029; n++) begin
      @(posedge clk); @(negedge clk);
      if (scrub_pass_done) begin
        pulses++;
        if (first_done < 0) first_done = n;
      end
      if (n == 1028) chk("scrub last addr", mem_addr, 8'hFF);
      if (n == 1029) chk("scrub wrap addr", mem_addr, 8'h00);
    end
    scrub_en = 1'b0;
    chk("pass_done cycle", first_done, 1026);
    chk("pass_done pulses", pulses, 1);
    chk("scrub err_flag", err_flag, 1);
    chk("scrub err_addr", err_addr, 8'h03);
    chk("scrub err_cnt", err_cnt, 1);
    @(posedge clk); @(negedge clk);

    // Host holds req_valid across the scrub deadline; scrub of addr 1 must follow right after
    scrub_en = 1'b1;
    acc = 0; rsp = 0; scrub_seen = -1;
    for (int i = 0; i < 20; i++) begin
      host_if.req_valid = (i < 16);
      host_if.req_wr    = 1'b0;
      host_if.req_addr  = 8'h10;
      if (host_if.req_valid && host_if.req_ready) acc++;
      if (host_if.rsp_valid) rsp++;
      if (i >= 16 && scrub_seen < 0 && mem_addr == 8'h01) scrub_seen = i;
      @(posedge clk); @(negedge clk);
    end
    host_if.req_valid = 1'b0;
    scrub_en = 1'b0;
    chk("defer accepts", acc, 8);
    chk("defer responses", rsp, 8);
    chk("defer scrub slot", scrub_seen, 17);
    @(posedge clk); @(negedge clk);

    // Reset in the WRITE cycle aborts the write and clears error state
    do_op(1'b0, 8'h03, 8'h00, 1'b0);
    chk("pre-reset err_flag", err_flag, 1);
    host_if.req_valid = 1'b1; host_if.req_wr = 1'b1;
    host_if.req_addr = 8'h20; host_if.req_wdata = 8'h5A;
    @(posedge clk); @(negedge clk);
    host_if.req_valid = 1'b0;
    chk("write state mem_wr", mem_wr, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("reset mem_wr drop", mem_wr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_after = 0;
    for (int i = 0; i < 4; i++) begin
      if (host_if.rsp_valid) rsp_after++;
      @(posedge clk); @(negedge clk);
    end
    chk("post-reset rsp_valid", rsp_after, 0);
    chk("post-reset req_ready", host_if.req_ready, 1);
    chk("post-reset err_flag", err_flag, 0);
    chk("post-reset err_cnt", err_cnt, 0);
    chk("post-reset err_addr", err_addr, 0);
    chk("aborted write mem", mem_d[8'h20], 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
